// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2, used to size digit/stage indices in cascade wrappers.
  function automatic int unsigned clog2(input longint unsigned n);
    int unsigned     r = 0;
    longint unsigned v = 64'd1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with parallel load, enable, cascade carry-in,
// registered wrap pulse (CO) and combinational terminal count (TC).
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     W       = 4,
  parameter longint unsigned MOD     = 16,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic         CLK,
  input  logic         MR,
  input  logic         EN,
  input  logic         CI,
  input  logic         UP,
  input  logic         LD,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         CO,
  output logic         TC
);

  if (W < 1 || W > 32) begin : g_bad_w
    $fatal(1, "updown_mod_counter: W must be within 1..32");
  end
  if (MOD < 2 || MOD > (64'd1 << W)) begin : g_bad_mod
    $fatal(1, "updown_mod_counter: MOD must be within 2..2^W");
  end
  if (RST_VAL >= MOD) begin : g_bad_rst
    $fatal(1, "updown_mod_counter: RST_VAL must be below MOD");
  end

  localparam logic [W-1:0] MAX_Q = W'(MOD - 64'd1);
  localparam logic [W-1:0] RST_Q = W'(RST_VAL);

  logic         step;
  logic         at_top;
  logic         at_bot;
  logic         wrap;
  logic         load_ok;
  logic [W-1:0] q_nxt;
  logic         co_nxt;

  // Wrap detection at W bits; when MOD == 2^W this matches natural overflow.
  assign step    = EN & CI;
  assign at_top  = (Q == MAX_Q);
  assign at_bot  = (Q == '0);
  assign wrap    = step & ((UP == DIR_UP) ? at_top : at_bot);
  assign load_ok = (64'(D) < MOD);
  assign TC      = wrap;

  // Next state: MR > LD > step > hold.
  always_comb begin
    q_nxt  = Q;
    co_nxt = 1'b0;
    if (MR) begin
      q_nxt = RST_Q;
    end else if (LD) begin
      q_nxt = load_ok ? D : '0;
    end else if (step) begin
      if (UP == DIR_UP) begin
        q_nxt = at_top ? '0 : Q + W'(1);
      end else begin
        q_nxt = at_bot ? MAX_Q : Q - W'(1);
      end
      co_nxt = wrap;
    end
  end

  always_ff @(posedge CLK) begin
    Q  <= q_nxt;
    CO <= co_nxt;
  end

`ifndef SYNTHESIS
  // Range check on Q, armed once the first reset has been seen.
  logic armed;
  always_ff @(posedge CLK) begin
    armed <= armed | MR;
    if (armed) begin
      assert (64'(Q) < MOD);
    end
  end
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: directed plan plus randomized stimulus against a
// modulo-arithmetic reference model, checked on every cycle.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stage A: W=4 MOD=10 RST=0. Stage B: W=4 MOD=16 RST=3. Chain: two MOD=10.
  logic       a_mr, a_en, a_ci, a_up, a_ld;
  logic [3:0] a_d, a_q;
  logic       a_co, a_tc;
  logic       b_mr, b_en, b_ci, b_up, b_ld;
  logic [3:0] b_d, b_q;
  logic       b_co, b_tc;
  logic       c_mr, c_en, c_up, c_ld, c_ci0;
  logic [3:0] c_d, c0_q, c1_q;
  logic       c0_co, c0_tc, c1_co, c1_tc;

  updown_mod_counter #(.W(4), .MOD(10), .RST_VAL(0)) u_a (
    .CLK(clk), .MR(a_mr), .EN(a_en), .CI(a_ci), .UP(a_up), .LD(a_ld),
    .D(a_d), .Q(a_q), .CO(a_co), .TC(a_tc));

  updown_mod_counter #(.W(4), .MOD(16), .RST_VAL(3)) u_b (
    .CLK(clk), .MR(b_mr), .EN(b_en), .CI(b_ci), .UP(b_up), .LD(b_ld),
    .D(b_d), .Q(b_q), .CO(b_co), .TC(b_tc));

  updown_mod_counter #(.W(4), .MOD(10), .RST_VAL(0)) u_c0 (
    .CLK(clk), .MR(c_mr), .EN(c_en), .CI(c_ci0), .UP(c_up), .LD(c_ld),
    .D(c_d), .Q(c0_q), .CO(c0_co), .TC(c0_tc));

  updown_mod_counter #(.W(4), .MOD(10), .RST_VAL(0)) u_c1 (
    .CLK(clk), .MR(c_mr), .EN(c_en), .CI(c0_tc), .UP(c_up), .LD(c_ld),
    .D(c_d), .Q(c1_q), .CO(c1_co), .TC(c1_tc));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: counting expressed as modular arithmetic.
  function automatic void mstep(input int q, input int mod, input int rst,
                                input logic mr, input logic ld, input int d,
                                input logic en, input logic ci, input logic up,
                                output int qn, output logic con);
    con = 1'b0;
    if (mr) qn = rst;
    else if (ld) qn = (d < mod) ? d : 0;
    else if (en && ci) begin
      if (up) begin
        qn  = (q + 1) % mod;
        con = (q + 1 == mod);
      end else begin
        qn  = (q + mod - 1) % mod;
        con = (q == 0);
      end
    end else qn = q;
  endfunction

  function automatic logic mtc(input int q, input int mod, input logic en,
                               input logic ci, input logic up);
    return en && ci && (up ? (q == mod - 1) : (q == 0));
  endfunction

  int   ma_q, mb_q, mc0_q, mc1_q;
  logic ma_co, mb_co, mc0_co, mc1_co;
  logic armed = 1'b0;

  always @(posedge clk) begin
    int   n;
    logic c;
    logic t0;
    t0 = mtc(mc0_q, 10, c_en, 1'b1, c_up);
    mstep(ma_q, 10, 0, a_mr, a_ld, int'(a_d), a_en, a_ci, a_up, n, c);
    ma_q = n; ma_co = c;
    mstep(mb_q, 16, 3, b_mr, b_ld, int'(b_d), b_en, b_ci, b_up, n, c);
    mb_q = n; mb_co = c;
    mstep(mc1_q, 10, 0, c_mr, c_ld, int'(c_d), c_en, t0, c_up, n, c);
    mc1_q = n; mc1_co = c;
    mstep(mc0_q, 10, 0, c_mr, c_ld, int'(c_d), c_en, 1'b1, c_up, n, c);
    mc0_q = n; mc0_co = c;
    if (a_mr && b_mr && c_mr) armed = 1'b1;
  end

  // Per-cycle compare, after inputs for the coming edge have settled.
  always @(negedge clk) begin
    logic t0;
    #1;
    if (armed) begin
      t0 = mtc(mc0_q, 10, c_en, 1'b1, c_up);
      chk("a_q",   a_q,   ma_q);
      chk("a_co",  a_co,  ma_co);
      chk("a_tc",  a_tc,  mtc(ma_q, 10, a_en, a_ci, a_up));
      chk("b_q",   b_q,   mb_q);
      chk("b_co",  b_co,  mb_co);
      chk("b_tc",  b_tc,  mtc(mb_q, 16, b_en, b_ci, b_up));
      chk("c0_q",  c0_q,  mc0_q);
      chk("c0_co", c0_co, mc0_co);
      chk("c0_tc", c0_tc, t0);
      chk("c1_q",  c1_q,  mc1_q);
      chk("c1_co", c1_co, mc1_co);
      chk("c1_tc", c1_tc, mtc(mc1_q, 10, c_en, t0, c_up));
    end
  end

  task automatic rand_ab();
    a_mr = ($urandom_range(0, 31) == 0);
    a_ld = ($urandom_range(0, 7) == 0);
    a_d  = 4'($urandom_range(0, 15));
    a_en = ($urandom_range(0, 3) != 0);
    a_ci = ($urandom_range(0, 3) != 0);
    a_up = 1'($urandom_range(0, 1));
    b_mr = ($urandom_range(0, 31) == 0);
    b_ld = ($urandom_range(0, 7) == 0);
    b_d  = 4'($urandom_range(0, 15));
    b_en = ($urandom_range(0, 3) != 0);
    b_ci = ($urandom_range(0, 3) != 0);
    b_up = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int exp2[3];
    int co1_cnt;
    int tc1_cnt;
    exp2 = '{9, 8, 7};
    {a_mr, a_en, a_ci, a_up, a_ld, a_d} = '0;
    {b_mr, b_en, b_ci, b_up, b_ld, b_d} = '0;
    {c_mr, c_en, c_up, c_ld, c_d} = '0;
    c_ci0 = 1'b1;
    a_mr = 1'b1; b_mr = 1'b1; c_mr = 1'b1;
    a_ci = 1'b1; b_ci = 1'b1;
    @(negedge clk);
    chk("rst_a_q", a_q, 0);
    chk("rst_a_co", a_co, 0);
    chk("rst_b_q", b_q, 3);
    chk("rst_c1c0", {c1_q, c0_q}, 0);

    // Count up through a wrap.
    a_mr = 1'b0; b_mr = 1'b0; c_mr = 1'b0;
    a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #2 chk("t1_tc", a_tc, (i == 9));
      @(negedge clk);
      chk("t1_q", a_q, (i + 1) % 10);
      chk("t1_co", a_co, (i == 9));
    end

    // Count down through a borrow.
    a_ld = 1'b1; a_d = 4'd0;
    @(negedge clk);
    chk("t2_ld0", a_q, 0);
    a_ld = 1'b0; a_up = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #2 chk("t2_tc", a_tc, (j == 0));
      @(negedge clk);
      chk("t2_q", a_q, exp2[j]);
      chk("t2_co", a_co, (j == 0));
    end

    // Out-of-range load, then load beating a pending borrow.
    a_ld = 1'b1; a_d = 4'd12; a_en = 1'b0;
    @(negedge clk);
    chk("t3_q_oor", a_q, 0);
    chk("t3_co", a_co, 0);
    a_d = 4'd7; a_en = 1'b1;
    @(negedge clk);
    chk("t3_q_ld", a_q, 7);
    chk("t3_co2", a_co, 0);

    // Reset beats a carry at the same edge.
    a_d = 4'd9;
    @(negedge clk);
    chk("t4_q9", a_q, 9);
    a_ld = 1'b0; a_up = 1'b1; a_mr = 1'b1;
    #2 chk("t4_tc", a_tc, 1);
    @(negedge clk);
    chk("t4_q", a_q, 0);
    chk("t4_co", a_co, 0);
    a_mr = 1'b0; a_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2 chk("t4_tc_hold", a_tc, 0);
      @(negedge clk);
      chk("t4_hold_q", a_q, 0);
      chk("t4_hold_co", a_co, 0);
    end

    // Full-range modulus: borrow and carry equal natural overflow.
    b_ld = 1'b1; b_d = 4'd0;
    @(negedge clk);
    chk("t5_ld0", b_q, 0);
    b_ld = 1'b0; b_en = 1'b1; b_up = 1'b0;
    #2 chk("t5_tc_dn", b_tc, 1);
    @(negedge clk);
    chk("t5_q15", b_q, 15);
    chk("t5_co_dn", b_co, 1);
    b_up = 1'b1;
    #2 chk("t5_tc_up", b_tc, 1);
    @(negedge clk);
    chk("t5_q0", b_q, 0);
    chk("t5_co_up", b_co, 1);
    b_en = 1'b0;
    @(negedge clk);
    chk("t5_co_pulse", b_co, 0);

    // Two-digit chain: 100 steps return to 00, with one carry out of digit 1.
    co1_cnt = 0;
    tc1_cnt = 0;
    c_en = 1'b1; c_up = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_ab();
      #2 if (c1_tc === 1'b1) tc1_cnt++;
      if (i == 99) chk("t6_tc1_at99", c1_tc, 1);
      @(negedge clk);
      if (c1_co === 1'b1) co1_cnt++;
      if (i == 49) chk("t6_mid", {c1_q, c0_q}, {4'd5, 4'd0});
    end
    chk("t6_q", {c1_q, c0_q}, 0);
    chk("t6_co1_cnt", co1_cnt, 1);
    chk("t6_tc1_cnt", tc1_cnt, 1);

    // Fully random phase, chain included.
    for (int i = 0; i < 400; i++) begin
      rand_ab();
      c_mr = ($urandom_range(0, 63) == 0);
      c_ld = ($urandom_range(0, 15) == 0);
      c_d  = 4'($urandom_range(0, 15));
      c_en = ($urandom_range(0, 3) != 0);
      c_up = ($urandom_range(0, 7) < 5);
      @(negedge clk);
    end

    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
